// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data-memory access controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_LDST     = 2'b11;

  localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/mem_stage_ctrl_timeout_cnt.sv
// Saturating wait-cycle counter; termCnt flags the last ACCESS cycle allowed before a timeout.
module mem_timeout_cnt
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  localparam int CntW = $clog2(TIMEOUT + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            enable,
  output logic [CntW-1:0] count,
  output logic            termCnt
);

  localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT);
  localparam logic [CntW-1:0] CntTerm = CntW'(TIMEOUT - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != CntMax)) begin
      count <= count + 1'b1;
    end
  end

  assign termCnt = (count == CntTerm);

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: issues one data-memory request per load/store, stalls the
// upstream pipeline while it is in flight, and reports load data or access faults.
module mem_stage_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_in,
  input  logic              st_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              stall,
  output logic [DATA_W-1:0] ld_data,
  output logic              ld_valid,
  output logic              err,
  output logic [1:0]        err_code,
  output state_e            stateDbg
);

  localparam int CntW = $clog2(TIMEOUT + 1);

  state_e            state;
  state_e            nextState;
  logic              accept;
  logic [1:0]        doneCode;
  logic              weQ;
  logic              cntClear;
  logic              cntEnable;
  logic [CntW-1:0]   cntValue;
  logic              termCnt;
  logic              loadHit;
  logic              timedOut;

  mem_timeout_cnt #(.TIMEOUT(TIMEOUT)) uTimeoutCnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (cntClear),
    .enable  (cntEnable),
    .count   (cntValue),
    .termCnt (termCnt)
  );

  assign cntClear  = (state == IDLE);
  assign cntEnable = (state == ACCESS) && !mem_ready;
  assign loadHit   = (state == ACCESS) && mem_ready && !weQ;
  assign timedOut  = (state == ACCESS) && !mem_ready && termCnt;
  assign mem_we    = weQ && (state == ACCESS);
  assign stateDbg  = state;

  // Handshake: a request is presented while mem_req is high; it completes in the
  // cycle where mem_req and mem_ready are both high, and the request fields hold until then.
  always_comb begin
    nextState = state;
    stall     = 1'b0;
    mem_req   = 1'b0;
    accept    = 1'b0;
    doneCode  = ERR_NONE;
    unique case (state)
      IDLE: begin
        stall = ld_in | st_in;
        if (ld_in && st_in) begin
          nextState = DONE;
          doneCode  = ERR_LDST;
        end else if (ld_in || st_in) begin
          if (addr_in[1:0] != 2'b00) begin
            nextState = DONE;
            doneCode  = ERR_MISALIGN;
          end else begin
            accept    = 1'b1;
            nextState = ACCESS;
          end
        end
      end
      ACCESS: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        // A completing handshake wins over a coincident terminal count.
        if (mem_ready) begin
          nextState = DONE;
        end else if (termCnt) begin
          nextState = DONE;
          doneCode  = ERR_TIMEOUT;
        end
      end
      DONE: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      weQ       <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ld_data   <= '0;
      ld_valid  <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      state    <= nextState;
      ld_valid <= 1'b0;
      err      <= 1'b0;
      if (accept) begin
        mem_addr  <= addr_in;
        mem_wdata <= wdata_in;
        weQ       <= st_in;
      end
      if (nextState == DONE) begin
        err_code <= doneCode;
        err      <= (doneCode != ERR_NONE);
        ld_valid <= loadHit;
      end
      if (loadHit) begin
        ld_data <= mem_rdata;
      end else if (timedOut) begin
        ld_data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed cases from the access rules, then random
// transactions scored against a transaction-level expectation model.
module tb_mem_stage_ctrl;
  import mem_ctrl_pkg::*;

  localparam int TB_TIMEOUT = 4;
  localparam int NEVER      = 1000;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_in = 1'b0;
  logic        st_in = 1'b0;
  logic [31:0] addr_in = '0;
  logic [31:0] wdata_in = '0;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        stall;
  logic [31:0] ld_data;
  logic        ld_valid;
  logic        err;
  logic [1:0]  err_code;
  state_e      stateDbg;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld_in     (ld_in),
    .st_in     (st_in),
    .addr_in   (addr_in),
    .wdata_in  (wdata_in),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .stall     (stall),
    .ld_data   (ld_data),
    .ld_valid  (ld_valid),
    .err       (err),
    .err_code  (err_code),
    .stateDbg  (stateDbg)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int          nChecks = 0;
  int          nErr = 0;
  logic [31:0] mdlLdData = '0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_q(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      nChecks++;
      nErr++;
      $error("FAIL %s observed=0x%08h expected=<none queued>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      check_val(tag, obs, e);
    end
  endtask

  // Expected outcome of one transaction, derived from the access rules:
  // request cycles, stall cycles, done-cycle pulses, error code and load data.
  task automatic model_txn(input logic ld, input logic st, input logic [31:0] addr,
                           input logic [31:0] rdata, input int waits);
    int          reqN;
    logic        ldv;
    logic        er;
    logic [1:0]  code;
    if (ld && st) begin
      reqN = 0; code = ERR_LDST; ldv = 1'b0;
    end else if (addr[1:0] != 2'b00) begin
      reqN = 0; code = ERR_MISALIGN; ldv = 1'b0;
    end else if (waits < TB_TIMEOUT) begin
      reqN = waits + 1; code = ERR_NONE; ldv = ld;
      if (ld) mdlLdData = rdata;
    end else begin
      reqN = TB_TIMEOUT; code = ERR_TIMEOUT; ldv = 1'b0;
      mdlLdData = '0;
    end
    er = (code != ERR_NONE);
    exp_q.push_back(32'(reqN));
    exp_q.push_back(32'(reqN + 1));
    exp_q.push_back(32'(ldv));
    exp_q.push_back(32'(er));
    exp_q.push_back(32'(code));
    exp_q.push_back(mdlLdData);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'(code));
  endtask

  // ---------------- driver ----------------
  task automatic apply_reset();
    rst_n = 1'b0;
    ld_in = 1'b0; st_in = 1'b0; mem_ready = 1'b0;
    mdlLdData = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Memory answers on ACCESS cycle number waits+1; waits >= TB_TIMEOUT means it never answers.
  task automatic run_txn(input logic ld, input logic st, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata, input int waits);
    int          reqN = 0;
    int          stallN = 0;
    int          cyc = 0;
    bit          done = 0;
    logic        bad = 1'b0;
    logic        ldv = 1'b0;
    logic        er = 1'b0;
    logic [1:0]  code = '0;
    logic [31:0] ldd = '0;
    model_txn(ld, st, addr, rdata, waits);
    @(negedge clk);
    ld_in = ld; st_in = st; addr_in = addr; wdata_in = wdata;
    while (!done && cyc < 100) begin
      #1;
      if (cyc > 0 && !stall) begin
        done = 1;
        ldv = ld_valid; er = err; code = err_code; ldd = ld_data;
        ld_in = 1'b0; st_in = 1'b0;
        mem_ready = 1'($urandom_range(0, 1));
      end else begin
        if (stall) stallN++;
        if (mem_req) begin
          if ((mem_we !== st) || (mem_addr !== addr) || (mem_wdata !== wdata)) bad = 1'b1;
          mem_ready = (reqN == waits);
          mem_rdata = (reqN == waits) ? rdata : $urandom;
          reqN++;
        end else begin
          // ready outside ACCESS must have no effect
          mem_ready = 1'($urandom_range(0, 1));
          mem_rdata = $urandom;
        end
        @(negedge clk);
        cyc++;
      end
    end
    check_val("done_reached", 32'(done), 32'd1);
    check_q("req_cycles", 32'(reqN));
    check_q("stall_cycles", 32'(stallN));
    check_q("ld_valid_done", 32'(ldv));
    check_q("err_done", 32'(er));
    check_q("err_code_done", 32'(code));
    check_q("ld_data_done", ldd);
    check_q("req_fields_stable", 32'(bad));
    @(negedge clk);
    #1;
    check_q("ld_valid_after", 32'(ld_valid));
    check_q("err_after", 32'(err));
    check_q("err_code_held", 32'(err_code));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          reqSeen;
    logic        ld;
    logic        st;
    logic [31:0] a;
    int          kind;
    apply_reset();
    #1;
    check_val("rst_mem_req", 32'(mem_req), 32'd0);
    check_val("rst_mem_we", 32'(mem_we), 32'd0);
    check_val("rst_stall", 32'(stall), 32'd0);
    check_val("rst_ld_valid", 32'(ld_valid), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    check_val("rst_err_code", 32'(err_code), 32'd0);
    check_val("rst_ld_data", ld_data, 32'd0);
    check_val("rst_mem_addr", mem_addr, 32'd0);
    check_val("rst_mem_wdata", mem_wdata, 32'd0);
    check_val("rst_state", 32'(stateDbg), 32'(IDLE));

    run_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'hCAFE_0001, 0);      // zero-wait load
    run_txn(1'b0, 1'b1, 32'h0000_0100, 32'h1234_5678, 32'h0, 3);      // store, 3 waits
    run_txn(1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'h0, NEVER);          // timeout
    run_txn(1'b1, 1'b0, 32'h0000_0013, 32'h0, 32'h0, 0);              // misaligned
    run_txn(1'b1, 1'b1, 32'h0000_0020, 32'h55AA_55AA, 32'h0, 0);      // both flags
    run_txn(1'b1, 1'b0, 32'h0000_0080, 32'h0, 32'hBEEF_F00D, TB_TIMEOUT - 1); // ready at terminal count

    // reset during the second ACCESS cycle
    @(negedge clk);
    ld_in = 1'b1; st_in = 1'b0; addr_in = 32'h0000_0024; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_val("midrst_req_before", 32'(mem_req), 32'd1);
    ld_in = 1'b0;
    rst_n = 1'b0;
    mdlLdData = '0;
    #1;
    check_val("midrst_req", 32'(mem_req), 32'd0);
    check_val("midrst_stall", 32'(stall), 32'd0);
    check_val("midrst_state", 32'(stateDbg), 32'(IDLE));
    check_val("midrst_ld_data", ld_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    reqSeen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      if (mem_req || stall) reqSeen++;
    end
    check_val("postrst_no_req", 32'(reqSeen), 32'd0);

    // randomized transactions
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      a = $urandom;
      a[1:0] = 2'b00;
      if (kind == 0) begin
        ld = 1'b1; st = 1'b1;
      end else begin
        ld = 1'($urandom_range(0, 1));
        st = !ld;
        if (kind == 1) a[1:0] = 2'($urandom_range(1, 3));
      end
      run_txn(ld, st, a, $urandom, $urandom, $urandom_range(0, TB_TIMEOUT + 1));
    end

    check_val("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end

endmodule
